// File: rtl/router_pkg.sv
// Shared router definitions: output port codes, header field offsets, head-register state.
// Port summary: none (package only).
// Imported by every router port and by the route calculator.
package router_pkg;

    // Output port codes carried in the target field
    localparam logic [7:0] PORT_N     = 8'd0;
    localparam logic [7:0] PORT_S     = 8'd1;
    localparam logic [7:0] PORT_E     = 8'd2;
    localparam logic [7:0] PORT_W     = 8'd3;
    localparam logic [7:0] PORT_LOCAL = 8'd4;

    // Header layout, offsets counted down from the packet width:
    // [W-1:W-8] target, [W-9:W-12] row, [W-13:W-16] column, [W-17] mode
    localparam int TGT_W    = 8;
    localparam int ROW_W    = 4;
    localparam int COL_W    = 4;
    localparam int ROW_HI   = 9;
    localparam int COL_HI   = 13;
    localparam int MODE_POS = 17;
    localparam int HDR_W    = ROW_W + COL_W + 1;   // routing-relevant header bits

    typedef enum logic {
        HEAD_EMPTY = 1'b0,
        HEAD_VALID = 1'b1
    } head_state_t;

endpackage

// File: rtl/router_in_port_if.sv
// Router input-port bus: terminal push side plus arbiter pop side and status.
// slave = the input port itself, master = whoever drives pushes/pops.
// Widths follow pckg_sz and Fif_Size so both ends agree.
interface router_in_port_if #(
    parameter int pckg_sz  = 40,
    parameter int Fif_Size = 10
);
    localparam int CW = $clog2(Fif_Size + 1);

    logic               push;
    logic [pckg_sz-1:0] Data_in;
    logic               full;
    logic               pndng_i;
    logic [pckg_sz-1:0] Data_out_i;
    logic               pop_i;
    logic [1:0]         Trn;
    logic [CW-1:0]      count;
    logic [15:0]        drop_cnt;

    modport slave (
        input  push, Data_in, pop_i, Trn,
        output full, pndng_i, Data_out_i, count, drop_cnt
    );

    modport master (
        output push, Data_in, pop_i, Trn,
        input  full, pndng_i, Data_out_i, count, drop_cnt
    );
endinterface

// File: rtl/route_calc.sv
// Dimension-ordered route calculator: header {row, col, mode} in, target port code out.
// Purely combinational, zero latency; no backpressure.
// mode=1 resolves rows first, mode=0 resolves columns first.
module route_calc
    import router_pkg::*;
#(
    parameter int id_r = 0,
    parameter int id_c = 0
) (
    input  logic [HDR_W-1:0] hdr,      // {row[3:0], col[3:0], mode}
    output logic [TGT_W-1:0] target
);
    localparam logic [ROW_W-1:0] MY_ROW = ROW_W'(id_r);
    localparam logic [COL_W-1:0] MY_COL = COL_W'(id_c);

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             mode;

    assign row  = hdr[HDR_W-1 -: ROW_W];
    assign col  = hdr[COL_W:1];
    assign mode = hdr[0];

    always_comb begin
        target = PORT_LOCAL;
        if (mode) begin
            if      (row < MY_ROW) target = PORT_N;
            else if (row > MY_ROW) target = PORT_S;
            else if (col > MY_COL) target = PORT_E;
            else if (col < MY_COL) target = PORT_W;
        end else begin
            if      (col > MY_COL) target = PORT_E;
            else if (col < MY_COL) target = PORT_W;
            else if (row < MY_ROW) target = PORT_N;
            else if (row > MY_ROW) target = PORT_S;
        end
    end
endmodule

// File: rtl/router_in_port.sv
// Router input port: head register + circular buffer FIFO, routed target on the head packet.
// Latency: push to pndng_i one cycle; pop reloads the head with no bubble.
// Backpressure: full when count==Fif_Size; pushes while full (and no pop) are dropped and counted.
module router_in_port
    import router_pkg::*;
#(
    parameter int pckg_sz  = 40,
    parameter int Fif_Size = 10,
    parameter int id       = 0,
    parameter int id_r     = 0,
    parameter int id_c     = 0,
    parameter int rows     = 4,
    parameter int columns  = 4
) (
    input  logic              clk,
    input  logic              rst,
    router_in_port_if.slave   bus
);
    localparam int CW    = $clog2(Fif_Size + 1);
    localparam int DEPTH = Fif_Size - 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW    = pckg_sz - TGT_W;   // target is never stored, it is recomputed

    // Keep the owning router's coordinates inside the mesh
    localparam int MY_R = (id_r < rows)    ? id_r : rows - 1;
    localparam int MY_C = (id_c < columns) ? id_c : columns - 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(Fif_Size);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [1:0]    MY_ID    = 2'(id);

    head_state_t      state_q, state_d;
    logic [BW-1:0]    head_q;
    logic [BW-1:0]    mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count_q;
    logic [15:0]      drop_q;
    logic [TGT_W-1:0] target;

    logic pop_acc, push_acc, buf_empty, full;
    logic head_ld_in, head_ld_buf, buf_wr, buf_rd;

    assign full      = (count_q == FULL_CNT);
    assign pop_acc   = bus.pop_i & (bus.Trn == MY_ID) & (state_q == HEAD_VALID);
    assign push_acc  = bus.push & (~full | pop_acc);
    // Head only empties once the buffer has drained, so count<=1 means buffer empty
    assign buf_empty = (count_q <= ONE_CNT);

    always_comb begin
        state_d     = state_q;
        head_ld_in  = 1'b0;
        head_ld_buf = 1'b0;
        buf_wr      = 1'b0;
        buf_rd      = 1'b0;
        case (state_q)
            HEAD_EMPTY: begin
                if (push_acc) begin
                    head_ld_in = 1'b1;
                    state_d    = HEAD_VALID;
                end
            end
            HEAD_VALID: begin
                if (pop_acc) begin
                    if (!buf_empty) begin
                        head_ld_buf = 1'b1;
                        buf_rd      = 1'b1;
                        buf_wr      = push_acc;
                    end else if (push_acc) begin
                        head_ld_in  = 1'b1;   // bypass straight into the head
                    end else begin
                        state_d     = HEAD_EMPTY;
                    end
                end else if (push_acc) begin
                    buf_wr = 1'b1;
                end
            end
            default: state_d = HEAD_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HEAD_EMPTY;
            head_q  <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            if (head_ld_in)       head_q <= bus.Data_in[BW-1:0];
            else if (head_ld_buf) head_q <= mem[rd_ptr];
            if (buf_rd) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            if (buf_wr) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + ONE_CNT;
                2'b01:   count_q <= count_q - ONE_CNT;
                default: count_q <= count_q;
            endcase
            if (bus.push && full && !pop_acc && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
        end
    end

    // Buffer storage carries no reset; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (!rst && buf_wr) mem[wr_ptr] <= bus.Data_in[BW-1:0];
    end

    route_calc #(.id_r(MY_R), .id_c(MY_C)) u_route (
        .hdr    (head_q[BW-1 -: HDR_W]),
        .target (target)
    );

    assign bus.full       = full;
    assign bus.pndng_i    = (state_q == HEAD_VALID);
    assign bus.Data_out_i = (state_q == HEAD_VALID) ? {target, head_q} : '0;
    assign bus.count      = count_q;
    assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_router_in_port.sv
module tb_router_in_port;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    router_in_port_if #(.pckg_sz(40), .Fif_Size(10)) if1 ();
    router_in_port_if #(.pckg_sz(40), .Fif_Size(10)) if2 ();

    router_in_port #(.pckg_sz(40), .Fif_Size(10), .id(0), .id_r(0), .id_c(0),
                     .rows(4), .columns(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    router_in_port #(.pckg_sz(40), .Fif_Size(10), .id(2), .id_r(1), .id_c(1),
                     .rows(4), .columns(4)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    int checks   = 0;
    int failures = 0;

    function automatic logic [39:0] mk(logic [3:0] r, logic [3:0] c, logic m, logic [22:0] pl);
        return {8'h00, r, c, m, pl};
    endfunction

    function automatic logic [39:0] routed(logic [39:0] p, logic [7:0] tgt);
        return {tgt, p[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [39:0] p;
    logic [39:0] pk2 [5];
    logic [7:0]  tg2 [5];

    initial begin
        rst = 1'b1;
        if1.push = 0; if1.Data_in = '0; if1.pop_i = 0; if1.Trn = 2'd0;
        if2.push = 0; if2.Data_in = '0; if2.pop_i = 0; if2.Trn = 2'd0;
        step(); step();
        rst = 1'b0;
        chk("rst_count", 64'(if1.count), 64'd0);
        chk("rst_pndng", 64'(if1.pndng_i), 64'd0);
        chk("rst_full",  64'(if1.full), 64'd0);
        chk("rst_drop",  64'(if1.drop_cnt), 64'd0);
        chk("rst_dout",  64'(if1.Data_out_i), 64'd0);

        // Single packet row=1 col=2 mode=1 at (0,0) -> south
        p = mk(4'd1, 4'd2, 1'b1, 23'h12345);
        if1.Data_in = p; if1.push = 1;
        step();
        if1.push = 0;
        chk("one_pndng", 64'(if1.pndng_i), 64'd1);
        chk("one_dout",  64'(if1.Data_out_i), 64'(routed(p, 8'd1)));
        chk("one_count", 64'(if1.count), 64'd1);

        // Pop with wrong turn does nothing
        if1.pop_i = 1; if1.Trn = 2'd1;
        step();
        chk("wrongtrn_count", 64'(if1.count), 64'd1);
        chk("wrongtrn_pndng", 64'(if1.pndng_i), 64'd1);
        if1.Trn = 2'd0;
        step();
        chk("pop1_count", 64'(if1.count), 64'd0);
        chk("pop1_pndng", 64'(if1.pndng_i), 64'd0);
        step();   // pop while empty
        chk("emptypop_count", 64'(if1.count), 64'd0);
        if1.pop_i = 0;

        // Fill to capacity, destination local (target 4)
        for (int i = 0; i < 10; i++) begin
            if1.Data_in = mk(4'd0, 4'd0, 1'b1, 23'(i)); if1.push = 1;
            step();
        end
        chk("fill_count", 64'(if1.count), 64'd10);
        chk("fill_full",  64'(if1.full), 64'd1);
        if1.Data_in = mk(4'd0, 4'd0, 1'b1, 23'd77);
        step();
        if1.push = 0;
        chk("drop_cnt",   64'(if1.drop_cnt), 64'd1);
        chk("drop_count", 64'(if1.count), 64'd10);

        if1.pop_i = 1;
        for (int i = 0; i < 10; i++) begin
            p = mk(4'd0, 4'd0, 1'b1, 23'(i));
            chk($sformatf("drain_pndng%0d", i), 64'(if1.pndng_i), 64'd1);
            chk($sformatf("drain_dout%0d", i), 64'(if1.Data_out_i), 64'(routed(p, 8'd4)));
            step();
        end
        if1.pop_i = 0;
        chk("drain_done_pndng", 64'(if1.pndng_i), 64'd0);
        chk("drain_done_count", 64'(if1.count), 64'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 10; i++) begin
            if1.Data_in = mk(4'd0, 4'd0, 1'b1, 23'(100 + i)); if1.push = 1;
            step();
        end
        if1.Data_in = mk(4'd0, 4'd0, 1'b1, 23'd200); if1.pop_i = 1;
        step();
        if1.push = 0; if1.pop_i = 0;
        chk("pp_count", 64'(if1.count), 64'd10);
        chk("pp_drop",  64'(if1.drop_cnt), 64'd1);
        chk("pp_full",  64'(if1.full), 64'd1);
        if1.pop_i = 1;
        for (int i = 0; i < 10; i++) begin
            p = mk(4'd0, 4'd0, 1'b1, (i < 9) ? 23'(101 + i) : 23'd200);
            chk($sformatf("pp_dout%0d", i), 64'(if1.Data_out_i), 64'(routed(p, 8'd4)));
            step();
        end
        if1.pop_i = 0;
        chk("pp_empty", 64'(if1.count), 64'd0);

        // Routing at router (1,1), port id 2
        pk2[0] = mk(4'd2, 4'd3, 1'b0, 23'h1); tg2[0] = 8'd2;
        pk2[1] = mk(4'd2, 4'd3, 1'b1, 23'h2); tg2[1] = 8'd1;
        pk2[2] = mk(4'd0, 4'd1, 1'b1, 23'h3); tg2[2] = 8'd0;
        pk2[3] = mk(4'd1, 4'd0, 1'b0, 23'h4); tg2[3] = 8'd3;
        pk2[4] = mk(4'd1, 4'd1, 1'b0, 23'h5); tg2[4] = 8'd4;
        for (int i = 0; i < 5; i++) begin
            if2.Data_in = pk2[i]; if2.push = 1;
            step();
        end
        if2.push = 0;
        if2.pop_i = 1; if2.Trn = 2'd0;
        step();
        chk("dut2_wrongtrn", 64'(if2.count), 64'd5);
        if2.Trn = 2'd2;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("route%0d", i), 64'(if2.Data_out_i), 64'(routed(pk2[i], tg2[i])));
            step();
        end
        if2.pop_i = 0;
        chk("dut2_empty", 64'(if2.count), 64'd0);

        // Reset wins over a push
        for (int i = 0; i < 5; i++) begin
            if1.Data_in = mk(4'd3, 4'd3, 1'b1, 23'(i)); if1.push = 1;
            step();
        end
        chk("pre_rst_count", 64'(if1.count), 64'd5);
        rst = 1'b1;
        step();
        chk("rst_push_count", 64'(if1.count), 64'd0);
        chk("rst_push_pndng", 64'(if1.pndng_i), 64'd0);
        chk("rst_push_drop",  64'(if1.drop_cnt), 64'd0);
        chk("rst_push_dout",  64'(if1.Data_out_i), 64'd0);
        rst = 1'b0; if1.push = 0;
        step();
        chk("post_rst_count", 64'(if1.count), 64'd0);
        chk("post_rst_pndng", 64'(if1.pndng_i), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
